// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the Aeolus fetch stage     |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package fetch_pkg;

    localparam int PC_W_DEF = 4;
    localparam int OP_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_LATCH = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    // Conditional-skip opcodes, shared with the decoder.
    localparam logic [OP_W_DEF-1:0] OP_SNZA = 4'h8;
    localparam logic [OP_W_DEF-1:0] OP_SNZS = 4'h9;

    function automatic logic is_skip_op(input logic [OP_W_DEF-1:0] op);
        return (op == OP_SNZA) || (op == OP_SNZS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pc_reg : program counter with load > skip > increment priority  |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module fetch_pc_reg #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic [PC_W-1:0] load_value,
    input  logic            skip,
    input  logic [PC_W-1:0] skip_base,
    input  logic            inc,
    output logic [PC_W-1:0] pc,
    output logic            wrap
);

    logic [PC_W:0]   sum;
    logic [PC_W-1:0] pc_next;

    // Skip advances two words past the held instruction, which is one past
    // the already-incremented pc; the carry bit flags a modulo wrap.
    always_comb begin
        sum     = {1'b0, pc} + (PC_W+1)'(1);
        pc_next = pc;
        wrap    = 1'b0;
        if (skip) begin
            sum = {1'b0, skip_base} + (PC_W+1)'(2);
        end
        if (load) begin
            pc_next = load_value;
        end else if (skip || inc) begin
            pc_next = sum[PC_W-1:0];
            wrap    = sum[PC_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : Aeolus instruction fetch (PC, ROM address, IR, handshake)|
// | Option     : FETCH_WRAP_HALT_EN halts fetch instead of wrapping pc    |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int OP_W = OP_W_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [PC_W-1:0] rom_addr,
    input  logic [OP_W-1:0] rom_data,
    output logic [OP_W-1:0] instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            skip,
    input  logic            pc_load,
    input  logic [PC_W-1:0] pc_load_value,
    output logic            halted
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic            accept;
    logic            pc_inc;
    logic            pc_skip;
`ifdef FETCH_WRAP_HALT_EN
    logic            pc_wrap;
    logic            wrap_pending;
`endif

    assign accept   = (state == ST_VALID) && instr_valid && instr_ready;
    assign pc_inc   = (state == ST_LATCH) && !pc_load;
    assign pc_skip  = accept && skip && !pc_load;
    assign rom_addr = pc;

    fetch_pc_reg #(
        .PC_W (PC_W)
    ) u_pc_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (pc_load),
        .load_value (pc_load_value),
        .skip       (pc_skip),
        .skip_base  (instr_pc),
        .inc        (pc_inc),
        .pc         (pc),
`ifdef FETCH_WRAP_HALT_EN
        .wrap       (pc_wrap)
`else
        .wrap       ()
`endif
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_FETCH;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
`ifdef FETCH_WRAP_HALT_EN
            halted       <= 1'b0;
            wrap_pending <= 1'b0;
`endif
        end else if (pc_load) begin
            // A redirect discards whatever is in flight, including a pending skip.
            state       <= ST_FETCH;
            instr_valid <= 1'b0;
`ifdef FETCH_WRAP_HALT_EN
            halted       <= 1'b0;
            wrap_pending <= 1'b0;
`endif
        end else begin
            case (state)
                ST_FETCH: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    instr       <= rom_data;
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                    state       <= ST_VALID;
`ifdef FETCH_WRAP_HALT_EN
                    wrap_pending <= pc_wrap;
`endif
                end
                ST_VALID: begin
                    if (accept) begin
                        instr_valid <= 1'b0;
`ifdef FETCH_WRAP_HALT_EN
                        // The last word before the wrap is still delivered; halt on its accept.
                        if (wrap_pending || pc_wrap) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                        wrap_pending <= 1'b0;
`else
                        state <= ST_FETCH;
`endif
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

`ifndef FETCH_WRAP_HALT_EN
    assign halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit : directed self-checking bench for fetch_unit           |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] rom_addr;
    logic [3:0] rom_data = 4'd0;
    logic [3:0] instr;
    logic [3:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic       skip = 1'b0;
    logic       pc_load = 1'b0;
    logic [3:0] pc_load_value = 4'd0;
    logic       halted;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .skip          (skip),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Identity program ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for instr_valid and checks the fetch latency and presented word.
    task automatic wait_valid(input int exp_lat, input logic [3:0] exp_pc, input string tag);
        int n;
        n = 0;
        while (!instr_valid && n < 8) begin
            tick();
            n++;
        end
        if (!instr_valid) n = 99;
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_pc"}, instr_pc, exp_pc);
        check({tag, "_instr"}, instr, exp_pc);
    endtask

    task automatic give_accept(input logic s);
        instr_ready = 1'b1;
        skip        = s;
        tick();
        instr_ready = 1'b0;
        skip        = 1'b0;
        check("accept_drop", instr_valid, 0);
    endtask

    task automatic do_load(input logic [3:0] v);
        pc_load       = 1'b1;
        pc_load_value = v;
        tick();
        pc_load = 1'b0;
        check("load_drop", instr_valid, 0);
        check("load_addr", rom_addr, v);
    endtask

    initial begin
        #12;
        check("rst_addr", rom_addr, 0);
        check("rst_instr", instr, 0);
        check("rst_ipc", instr_pc, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_halted", halted, 0);

        // Release reset with ready high: back-to-back fetch at 3 cycles each.
        tick();
        reset_n     = 1'b1;
        instr_ready = 1'b1;
        tick();
        check("first_not_yet", instr_valid, 0);
        tick();
        check("first_valid", instr_valid, 1);
        check("first_instr", instr, 0);
        check("first_ipc", instr_pc, 0);
        check("first_addr", rom_addr, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("thru_gap", instr_valid, 0);
            tick();
            tick();
            check("thru_valid", instr_valid, 1);
            check("thru_instr", instr, k);
            check("thru_ipc", instr_pc, k);
        end
        instr_ready = 1'b0;

        // Stall: nothing moves while ready is low.
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall_valid", instr_valid, 1);
            check("stall_instr", instr, 3);
            check("stall_ipc", instr_pc, 3);
            check("stall_addr", rom_addr, 4);
        end

        give_accept(1'b0);
        wait_valid(2, 4'd4, "next4");
        give_accept(1'b1);
        wait_valid(2, 4'd6, "skip6");

        // Redirect during LATCH discards the in-flight word.
        give_accept(1'b0);
        tick();
        do_load(4'd12);
        wait_valid(2, 4'd12, "load12");

        // Load together with accept: load wins, old word not re-presented.
        instr_ready = 1'b1;
        do_load(4'd9);
        instr_ready = 1'b0;
        wait_valid(2, 4'd9, "loadacc9");

        do_load(4'd15);
        wait_valid(2, 4'd15, "at15");
`ifdef FETCH_WRAP_HALT_EN
        give_accept(1'b0);
        tick();
        tick();
        check("halt_flag", halted, 1);
        check("halt_valid", instr_valid, 0);
        do_load(4'd3);
        check("halt_clear", halted, 0);
        wait_valid(2, 4'd3, "recover3");
`else
        give_accept(1'b0);
        wait_valid(2, 4'd0, "wrap0");
        do_load(4'd15);
        wait_valid(2, 4'd15, "at15b");
        give_accept(1'b1);
        wait_valid(2, 4'd1, "skipwrap1");
        check("no_halt", halted, 0);
`endif

        // Asynchronous reset while presenting pc 7.
        do_load(4'd7);
        wait_valid(2, 4'd7, "pre_rst7");
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_valid", instr_valid, 0);
        check("arst_instr", instr, 0);
        check("arst_ipc", instr_pc, 0);
        check("arst_addr", rom_addr, 0);
        check("arst_halted", halted, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("restart_wait", instr_valid, 0);
        tick();
        check("restart_valid", instr_valid, 1);
        check("restart_ipc", instr_pc, 0);
        check("restart_instr", instr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
